// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rsa_pkg
// Description : Shared definitions for the RSA modular-exponentiation
//               sequencer: default operand/counter widths, the unit constant
//               and the 4-bit controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rsa_pkg;

    localparam int DEFAULT_WIDTH = 128;
    localparam int DEFAULT_CNT_W = 8;

    localparam logic [DEFAULT_WIDTH-1:0] ONE = {{(DEFAULT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_BRED   = 4'd1,
        ST_BRED_W = 4'd2,
        ST_SQ_M   = 4'd3,
        ST_SQ_MW  = 4'd4,
        ST_SQ_D   = 4'd5,
        ST_SQ_DW  = 4'd6,
        ST_ML_M   = 4'd7,
        ST_ML_MW  = 4'd8,
        ST_ML_D   = 4'd9,
        ST_ML_DW  = 4'd10,
        ST_NEXT   = 4'd11,
        ST_DONE   = 4'd12
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rsa_msb_index.sv
`default_nettype none
// ============================================================================
// Module      : rsa_msb_index
// Description : Combinational priority encoder. Returns the index of the
//               highest set bit of i_value and flags an all-zero input
//               (o_index is 0 in that case).
// Ports       : i_value [WIDTH]  value to scan
//               o_index [CNT_W]  index of highest set bit
//               o_zero           i_value == 0
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_msb_index #(
    parameter int WIDTH = 128,
    parameter int CNT_W = 8
) (
    input  logic [WIDTH-1:0] i_value,
    output logic [CNT_W-1:0] o_index,
    output logic             o_zero
);

    // Ascending scan: the last set bit seen wins, i.e. the most significant.
    always_comb begin
        o_index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_value[i]) begin
                o_index = CNT_W'(i);
            end
        end
    end

    assign o_zero = ~|i_value;

endmodule
`default_nettype wire

// File: rtl/rsa_modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rsa_modexp_ctrl
// Description : MSB-first square-and-multiply sequencer computing
//               result = base^exponent mod modulus. All wide arithmetic is
//               delegated to an external WIDTHxWIDTH multiplier and an
//               external 2*WIDTH / WIDTH remainder unit via start/done
//               handshakes.
// Config      : RSA_MODEXP_SKIP_LZ_EN - when defined, the bit scan starts at
//               the exponent's highest set bit instead of bit WIDTH-1,
//               skipping squarings of leading zeros. Results are identical.
// Ports       : clk, reset_n (async, active-low)
//               start, base, exponent, modulus  - command (sampled on accept)
//               busy, done, error, result        - status / result
//               mul_start, mul_a, mul_b, mul_done, mul_product - multiplier
//               div_start, div_dividend, div_divisor, div_done,
//               div_remainder                    - remainder unit
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   base,
    input  logic [WIDTH-1:0]   exponent,
    input  logic [WIDTH-1:0]   modulus,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [WIDTH-1:0]   result,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic               mul_done,
    input  logic [2*WIDTH-1:0] mul_product,
    output logic               div_start,
    output logic [2*WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0]   div_divisor,
    input  logic               div_done,
    input  logic [WIDTH-1:0]   div_remainder
);

    localparam int             IDX_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [WIDTH-1:0]   r_base;
    logic [WIDTH-1:0]   r_exp;
    logic [WIDTH-1:0]   r_mod;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_bred;
    logic [CNT_W-1:0]   r_idx;
    logic               r_exp_zero;

    logic [CNT_W-1:0]   w_idx_init;
    logic               w_exp_zero;
    logic               w_exp_bit;
    logic [WIDTH-1:0]   w_final;

`ifdef RSA_MODEXP_SKIP_LZ_EN
    rsa_msb_index #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_msb_index (
        .i_value (exponent),
        .o_index (w_idx_init),
        .o_zero  (w_exp_zero)
    );
`else
    assign w_idx_init = CNT_W'(WIDTH - 1);
    assign w_exp_zero = 1'b0;
`endif

    assign w_exp_bit = r_exp[r_idx[IDX_W-1:0]];

    // acc is already reduced after any squaring; only the untouched acc=1
    // (exponent==0 skip path) can still exceed a modulus of 1.
    assign w_final = ((r_acc == c_one) && (r_mod == c_one)) ? '0 : r_acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_base       <= '0;
            r_exp        <= '0;
            r_mod        <= '0;
            r_acc        <= '0;
            r_bred       <= '0;
            r_idx        <= '0;
            r_exp_zero   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            result       <= '0;
            mul_start    <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
            div_start    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
        end else begin
            // Request strobes are single-cycle pulses.
            mul_start <= 1'b0;
            div_start <= 1'b0;

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_base      <= base;
                        r_exp       <= exponent;
                        r_mod       <= modulus;
                        r_exp_zero  <= w_exp_zero;
                        div_divisor <= modulus;
                        result      <= '0;
                        if (modulus == '0) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            error   <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            busy    <= 1'b1;
                            done    <= 1'b0;
                            error   <= 1'b0;
                            r_acc   <= c_one;
                            r_idx   <= w_idx_init;
                            r_state <= ST_BRED;
                        end
                    end
                end

                ST_BRED: begin
                    div_start    <= 1'b1;
                    div_dividend <= {{WIDTH{1'b0}}, r_base};
                    r_state      <= ST_BRED_W;
                end

                ST_BRED_W: begin
                    if (div_done) begin
                        r_bred  <= div_remainder;
                        // Zero exponent with leading-zero skip: no bits to scan,
                        // acc stays 1 and r_idx is already 0.
                        r_state <= r_exp_zero ? ST_NEXT : ST_SQ_M;
                    end
                end

                ST_SQ_M: begin
                    mul_start <= 1'b1;
                    mul_a     <= r_acc;
                    mul_b     <= r_acc;
                    r_state   <= ST_SQ_MW;
                end

                ST_SQ_MW: begin
                    if (mul_done) begin
                        div_dividend <= mul_product;
                        r_state      <= ST_SQ_D;
                    end
                end

                ST_SQ_D: begin
                    div_start <= 1'b1;
                    r_state   <= ST_SQ_DW;
                end

                ST_SQ_DW: begin
                    if (div_done) begin
                        r_acc   <= div_remainder;
                        r_state <= w_exp_bit ? ST_ML_M : ST_NEXT;
                    end
                end

                ST_ML_M: begin
                    mul_start <= 1'b1;
                    mul_a     <= r_acc;
                    mul_b     <= r_bred;
                    r_state   <= ST_ML_MW;
                end

                ST_ML_MW: begin
                    if (mul_done) begin
                        div_dividend <= mul_product;
                        r_state      <= ST_ML_D;
                    end
                end

                ST_ML_D: begin
                    div_start <= 1'b1;
                    r_state   <= ST_ML_DW;
                end

                ST_ML_DW: begin
                    if (div_done) begin
                        r_acc   <= div_remainder;
                        r_state <= ST_NEXT;
                    end
                end

                ST_NEXT: begin
                    if (r_idx == '0) begin
                        result  <= w_final;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx   <= r_idx - CNT_W'(1);
                        r_state <= ST_SQ_M;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/rsa_modexp_ctrl.md
Name: rsa_modexp_ctrl

Overview:
- Sequencer for RSA modular exponentiation: result = base^exponent mod modulus.
- Uses MSB-first square-and-multiply.
- Does no wide arithmetic itself. It drives an external WIDTH×WIDTH multiplier and an external 2·WIDTH÷WIDTH divider (remainder only) through start/done handshakes.
- Sits between the RSA top-level command register and the shared multiply and divide datapaths.

Parameters:
- WIDTH, 128: operand width for base, exponent, modulus and result.
- CNT_W, 8: bit-index counter width; must satisfy 2^CNT_W ≥ WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE or DONE.
- base  in  WIDTH  base operand; sampled on accepted start.
- exponent  in  WIDTH  exponent; sampled on accepted start.
- modulus  in  WIDTH  modulus; sampled on accepted start.
- busy  out  1  high from accepted start until DONE.
- done  out  1  high in DONE; held until the next accepted start.
- error  out  1  high with done when modulus==0.
- result  out  WIDTH  final value; valid while done=1.
- mul_start  out  1  one-cycle multiply request.
- mul_a  out  WIDTH  multiplicand.
- mul_b  out  WIDTH  multiplier.
- mul_done  in  1  one-cycle multiply completion.
- mul_product  in  2·WIDTH  product; valid with mul_done.
- div_start  out  1  one-cycle reduce request.
- div_dividend  out  2·WIDTH  value to reduce.
- div_divisor  out  WIDTH  always the latched modulus.
- div_done  in  1  one-cycle divide completion.
- div_remainder  in  WIDTH  remainder; valid with div_done.

Behaviour:
- Reset state: IDLE. busy, done, error, mul_start and div_start are 0. result, mul_a, mul_b, div_dividend and div_divisor are 0.
- Reset mid-operation aborts immediately. No pending unit completion is honoured afterwards.
- States: IDLE, BRED, BRED_W, SQ_M, SQ_MW, SQ_D, SQ_DW, ML_M, ML_MW, ML_D, ML_DW, NEXT, DONE.
- Accepted start:
  - Latch base, exponent and modulus. Clear done and error. Set busy.
  - If modulus==0: go to DONE with error=1 and result=0.
  - Otherwise set acc=1, set idx=WIDTH-1 and go to BRED.
- BRED: pulse div_start with div_dividend={0,base}. Then go to BRED_W.
- BRED_W: wait for div_done. Then set bred=div_remainder and go to SQ_M.
- SQ_M: pulse mul_start with mul_a=mul_b=acc. Then go to SQ_MW.
- SQ_MW: on mul_done, latch mul_product into div_dividend. Then go to SQ_D.
- SQ_D: pulse div_start. Then go to SQ_DW.
- SQ_DW: on div_done, set acc=div_remainder.
  - If exponent[idx]=1: go to ML_M.
  - Otherwise: go to NEXT.
- ML_M, ML_MW, ML_D, ML_DW: same sequence as the SQ_ states, but with mul_a=acc and mul_b=bred. End at NEXT.
- NEXT:
  - If idx==0: set result = acc mod modulus and go to DONE.
  - Otherwise: idx-=1 and go to SQ_M.
- Special case modulus==1: result=0. This falls out naturally because every remainder is 0. Final correction: if acc==1 and modulus==1, force 0.
- Special case exponent==0: result = 1 mod modulus.
- Handshake rules:
  - Operand outputs are stable from the start pulse until the matching done.
  - Each unit has at most one request outstanding.
  - mul_done and div_done are ignored outside their _W/_MW/_DW wait states.
  - Simultaneous mul_done and div_done cannot be legitimate. Each is honoured only in its own wait state.
- start while busy is ignored.
- start in DONE is accepted; done drops the cycle after acceptance.
- Unit-op count without the optional feature: WIDTH squarings + popcount(exponent) multiplies, plus 1 base reduction.
- Controller overhead: 5 cycles per square and per multiply, plus unit latencies.

Optional Feature:
- Macro: RSA_MODEXP_SKIP_LZ_EN.
- With the macro defined:
  - On start, idx is loaded with the index of the exponent's highest set bit, computed by a priority encoder.
  - If exponent==0, go directly from BRED_W to NEXT-final with acc=1.
  - Squarings drop to msb+1.
- Without the macro: idx=WIDTH-1 always.
- result is identical in both builds. Only op count and latency differ.

Decomposition:
- Package rsa_pkg holds:
  - the state enum localparams (4-bit encoding);
  - the default WIDTH and CNT_W;
  - a constant ONE = {{WIDTH-1{1'b0}},1'b1}.
- One sub-module, rsa_msb_index: combinational priority encoder returning the highest set bit index and a zero flag. It is instantiated only under RSA_MODEXP_SKIP_LZ_EN.

Test Plan:
- Test setup: bench models a 3-cycle multiplier and a 7-cycle divider.
- 4^13 mod 497 → result=445, error=0.
  - Without the feature: mul_start pulse count=131.
  - With the feature: mul_start pulse count=7.
- 10^3 mod 7, where base exceeds modulus → result=6. BRED produces bred=3.
- exponent=0, base=5, modulus=11 → result=1. modulus=1 with any base/exponent → result=0.
- modulus=0 → done=1 and error=1 within 2 cycles of start. No mul_start or div_start is issued.
- Two back-to-back requests:
  - start pulsed while busy → ignored.
  - Spurious mul_done injected during SQ_DW → ignored; result is still correct.
- reset_n asserted during ML_MW → all outputs 0 asynchronously, state IDLE.
  - A subsequent start with 2^10 mod 1000 → result=24.
